multi_pipe_game_controller: RTL and testbench

Parametrised successor to the single-pipe game controller: runs the bird game state machine over `NUM_PIPES` independently scrolling pipes with per-pipe gap heights, a score counter and a timed death sequence. It sits between the input/physics logic (supplies `bird_y`, `start_button`, `frame_tick`) and the renderer (consumes pipe positions, `state`, `score`).

---
 rtl/multi_pipe_game_controller.sv | 204 ++++++++++++++++++++
 tb/tb_multi_pipe_game_controller.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_pipe_game_controller.sv
// Bird game controller over NUM_PIPES scrolling pipes: PLAY/DYING/OVER FSM, score and collision.
// Optional macro GAME_CTRL_HISCORE_EN adds a hi_score output that survives restarts.
module multi_pipe_game_controller #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int NUM_PIPES     = 3,
    parameter int PIPE_WIDTH    = 50,
    parameter int PIPE_GAP      = 100,
    parameter int PIPE_SPACING  = 240,
    parameter int GAP_MIN       = 20,
    parameter int BIRD_X        = 100,
    parameter int BIRD_WIDTH    = 20,
    parameter int BIRD_HEIGHT   = 20,
    parameter int DEATH_FRAMES  = 30,
    parameter int XW            = 11,
    parameter int SCORE_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_tick,
    input  logic                    start_button,
    input  logic [9:0]              bird_y,
    input  logic [9:0]              gap_seed,
    output logic [NUM_PIPES*XW-1:0] pipe_x,
    output logic [NUM_PIPES*10-1:0] pipe_y,
    output logic                    collision_out,
    output logic [1:0]              state,
`ifdef GAME_CTRL_HISCORE_EN
    output logic [SCORE_W-1:0]      hi_score,
`endif
    output logic [SCORE_W-1:0]      score
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DYING = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam int DW = $clog2(DEATH_FRAMES + 1);
    localparam logic [DW-1:0] DEATH_LAST = DW'(DEATH_FRAMES - 1);
    localparam logic [XW-1:0] WRAP_X     = XW'(NUM_PIPES * PIPE_SPACING - 1);
    localparam logic [XW-1:0] SCORE_X    = XW'(BIRD_X - PIPE_WIDTH);
    localparam logic [9:0]    Y_INIT     = 10'((SCREEN_HEIGHT - PIPE_GAP) / 2);
    localparam logic [9:0]    GAP_LO     = 10'(GAP_MIN);
    localparam logic [9:0]    GAP_HI     = 10'(SCREEN_HEIGHT - PIPE_GAP - GAP_MIN);
    localparam logic [11:0]   BX12 = 12'(BIRD_X);
    localparam logic [11:0]   BW12 = 12'(BIRD_WIDTH);
    localparam logic [11:0]   BH12 = 12'(BIRD_HEIGHT);
    localparam logic [11:0]   PW12 = 12'(PIPE_WIDTH);
    localparam logic [11:0]   GP12 = 12'(PIPE_GAP);
    localparam logic [11:0]   SH12 = 12'(SCREEN_HEIGHT);

    state_t               state_q, state_d;
    logic                 start_q, start_d;
    logic                 collision_q, collision_d;
    logic [DW-1:0]        death_q, death_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [XW-1:0]        pipe_x_q [NUM_PIPES];
    logic [XW-1:0]        pipe_x_d [NUM_PIPES];
    logic [9:0]           pipe_y_q [NUM_PIPES];
    logic [9:0]           pipe_y_d [NUM_PIPES];
`ifdef GAME_CTRL_HISCORE_EN
    logic [SCORE_W-1:0]   hi_q, hi_d;
`endif

    logic        start_rise;
    logic        hit;
    logic        passed;
    logic [11:0] bird_top, bird_bot, px, py;

    function automatic logic [XW-1:0] init_x(input int i);
        return XW'(SCREEN_WIDTH + i * PIPE_SPACING);
    endfunction

    function automatic logic [9:0] clamp_gap(input logic [9:0] s);
        if (s < GAP_LO) return GAP_LO;
        if (s > GAP_HI) return GAP_HI;
        return s;
    endfunction

    assign start_rise = start_button & ~start_q;

    // Floor or any pipe body overlapping the bird box; all sums in 12 bits.
    always_comb begin
        bird_top = {2'b00, bird_y};
        bird_bot = bird_top + BH12;
        hit      = (bird_bot >= SH12);
        px       = '0;
        py       = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            px = 12'(pipe_x_q[i]);
            py = {2'b00, pipe_y_q[i]};
            if ((BX12 < px + PW12) && (px < BX12 + BW12) &&
                ((bird_top < py) || (bird_bot > py + GP12)))
                hit = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_d     = start_button;
        collision_d = collision_q;
        death_d     = death_q;
        score_d     = score_q;
        pipe_x_d    = pipe_x_q;
        pipe_y_d    = pipe_y_q;
        passed      = 1'b0;
`ifdef GAME_CTRL_HISCORE_EN
        hi_d        = hi_q;
`endif
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_rise) begin
                    state_d     = S_PLAY;
                    collision_d = 1'b0;
                    death_d     = '0;
                    score_d     = '0;
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        pipe_x_d[i] = init_x(i);
                        pipe_y_d[i] = Y_INIT;
                    end
                end
            end
            S_PLAY: begin
                // The registered flag, not the raw hit, moves us on: one cycle later.
                if (collision_q) state_d = S_DYING;
                collision_d = collision_q | hit;
                if (frame_tick) begin
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        if (pipe_x_q[i] == SCORE_X) passed = 1'b1;
                        if (pipe_x_q[i] == '0) begin
                            pipe_x_d[i] = WRAP_X;
                            pipe_y_d[i] = clamp_gap(gap_seed);
                        end else begin
                            pipe_x_d[i] = pipe_x_q[i] - 1'b1;
                        end
                    end
                    if (passed && (score_q != '1)) score_d = score_q + 1'b1;
                end
            end
            S_DYING: begin
                if (frame_tick) begin
                    if (death_q == DEATH_LAST) begin
                        state_d = S_OVER;
                        death_d = '0;
`ifdef GAME_CTRL_HISCORE_EN
                        if (score_q > hi_q) hi_d = score_q;
`endif
                    end else begin
                        death_d = death_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            collision_q <= 1'b0;
            death_q     <= '0;
            score_q     <= '0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                pipe_x_q[i] <= init_x(i);
                pipe_y_q[i] <= Y_INIT;
            end
`ifdef GAME_CTRL_HISCORE_EN
            hi_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            collision_q <= collision_d;
            death_q     <= death_d;
            score_q     <= score_d;
            pipe_x_q    <= pipe_x_d;
            pipe_y_q    <= pipe_y_d;
`ifdef GAME_CTRL_HISCORE_EN
            hi_q        <= hi_d;
`endif
        end
    end

    always_comb begin
        pipe_x = '0;
        pipe_y = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            pipe_x[i*XW +: XW] = pipe_x_q[i];
            pipe_y[i*10 +: 10] = pipe_y_q[i];
        end
    end

    assign state         = state_q;
    assign collision_out = collision_q;
    assign score         = score_q;
`ifdef GAME_CTRL_HISCORE_EN
    assign hi_score      = hi_q;
`endif

endmodule

// File: tb/tb_multi_pipe_game_controller.sv
// Bench for multi_pipe_game_controller: scripted game scenarios plus random play,
// every cycle compared against a behavioural game model.
module tb_multi_pipe_game_controller;
  localparam int NP = 3, XW = 11, SW = 8;
  localparam int SCR_W = 640, SCR_H = 480, PIPE_W = 50, GAP = 100, SPACING = 240;
  localparam int GAP_MIN = 20, BIRD_X = 100, BIRD_W = 20, BIRD_H = 20, DEATH = 30;

  logic clk = 1'b0;
  logic reset, frame_tick, start_button;
  logic [9:0] bird_y, gap_seed;
  logic [NP*XW-1:0] pipe_x;
  logic [NP*10-1:0] pipe_y;
  logic collision_out;
  logic [1:0] state;
  logic [SW-1:0] score;
`ifdef GAME_CTRL_HISCORE_EN
  logic [SW-1:0] hi_score;
`endif

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  // model of the game
  int m_state, m_score, m_death, m_hi;
  bit m_coll, m_startq;
  int m_px[NP];
  int m_py[NP];

  // stimulus modes
  bit follow = 1'b1;
  bit use_forced = 1'b0;
  int forced_seed = 0;

  multi_pipe_game_controller dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_button(start_button),
    .bird_y(bird_y), .gap_seed(gap_seed), .pipe_x(pipe_x), .pipe_y(pipe_y),
    .collision_out(collision_out), .state(state),
`ifdef GAME_CTRL_HISCORE_EN
    .hi_score(hi_score),
`endif
    .score(score)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_score = 0; m_death = 0; m_coll = 0; m_startq = 0; m_hi = 0;
    for (int i = 0; i < NP; i++) begin
      m_px[i] = SCR_W + i * SPACING;
      m_py[i] = (SCR_H - GAP) / 2;
    end
  endtask

  function automatic int clamp_seed(input int s);
    if (s < GAP_MIN) return GAP_MIN;
    if (s > SCR_H - GAP - GAP_MIN) return SCR_H - GAP - GAP_MIN;
    return s;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int n_px[NP];
    int n_py[NP];
    int n_state, n_score, n_death, n_hi, by;
    bit n_coll, hit, rise, passed;
    by = int'(bird_y);
    rise = start_button && !m_startq;
    hit = (by + BIRD_H >= SCR_H);
    for (int i = 0; i < NP; i++)
      if (m_px[i] < BIRD_X + BIRD_W && m_px[i] + PIPE_W > BIRD_X &&
          (by < m_py[i] || by + BIRD_H > m_py[i] + GAP)) hit = 1;
    n_px = m_px; n_py = m_py;
    n_state = m_state; n_score = m_score; n_death = m_death; n_hi = m_hi; n_coll = m_coll;
    passed = 0;
    case (m_state)
      0, 3: if (rise) begin
        n_state = 1; n_score = 0; n_coll = 0; n_death = 0;
        for (int i = 0; i < NP; i++) begin
          n_px[i] = SCR_W + i * SPACING;
          n_py[i] = (SCR_H - GAP) / 2;
        end
      end
      1: begin
        if (m_coll) n_state = 2;
        if (hit) n_coll = 1;
        if (frame_tick) begin
          for (int i = 0; i < NP; i++) begin
            if (m_px[i] == BIRD_X - PIPE_W) passed = 1;
            if (m_px[i] == 0) begin
              n_px[i] = NP * SPACING - 1;
              n_py[i] = clamp_seed(int'(gap_seed));
            end else n_px[i] = m_px[i] - 1;
          end
          if (passed && m_score < (1 << SW) - 1) n_score = m_score + 1;
        end
      end
      default: if (frame_tick) begin
        if (m_death + 1 == DEATH) begin
          n_state = 3; n_death = 0;
          if (m_score > m_hi) n_hi = m_score;
        end else n_death = m_death + 1;
      end
    endcase
    m_px = n_px; m_py = n_py;
    m_state = n_state; m_score = n_score; m_death = n_death; m_hi = n_hi; m_coll = n_coll;
    m_startq = start_button;
  endtask

  task automatic push_expect();
    exp_q.push_back(32'(m_state));
    exp_q.push_back(32'(m_score));
    exp_q.push_back(32'(m_coll));
    for (int i = 0; i < NP; i++) exp_q.push_back(32'(m_px[i]));
    for (int i = 0; i < NP; i++) exp_q.push_back(32'(m_py[i]));
    exp_q.push_back(32'(m_hi));
  endtask

  task automatic compare_all();
    logic [31:0] e;
    e = exp_q.pop_front(); check_val("state", 32'(state), e);
    e = exp_q.pop_front(); check_val("score", 32'(score), e);
    e = exp_q.pop_front(); check_val("collision", 32'(collision_out), e);
    for (int i = 0; i < NP; i++) begin
      e = exp_q.pop_front(); check_val($sformatf("pipe_x%0d", i), 32'(pipe_x[i*XW +: XW]), e);
    end
    for (int i = 0; i < NP; i++) begin
      e = exp_q.pop_front(); check_val($sformatf("pipe_y%0d", i), 32'(pipe_y[i*10 +: 10]), e);
    end
    e = exp_q.pop_front();
`ifdef GAME_CTRL_HISCORE_EN
    check_val("hi_score", 32'(hi_score), e);
`endif
  endtask

  task automatic cycle();
    model_step();
    push_expect();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  function automatic int safe_y();
    int y = 190;
    for (int i = 0; i < NP; i++)
      if (m_px[i] < BIRD_X + BIRD_W && m_px[i] + PIPE_W > BIRD_X) y = m_py[i];
    return y;
  endfunction

  task automatic drive_pre();
    if (follow) bird_y = 10'(safe_y());
    if (use_forced && m_px[0] == 0) gap_seed = 10'(forced_seed);
    else gap_seed = 10'($urandom_range(0, 1023));
  endtask

  task automatic do_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) begin
        drive_pre(); frame_tick = 1'b0; cycle();
      end
      drive_pre(); frame_tick = 1'b1; cycle();
      frame_tick = 1'b0;
    end
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    model_reset();
    repeat (2) begin
      @(posedge clk); #1;
      push_expect(); compare_all();
    end
    reset = 1'b1;
  endtask

  task automatic press_start();
    start_button = 1'b1; cycle();
    start_button = 1'b0;
  endtask

  initial begin
    reset = 1'b0; frame_tick = 1'b0; start_button = 1'b0;
    bird_y = 10'd190; gap_seed = 10'd0;
    reset_dut();
    check_val("rst_px0", 32'(pipe_x[0 +: XW]), 640);
    check_val("rst_px1", 32'(pipe_x[XW +: XW]), 880);
    check_val("rst_px2", 32'(pipe_x[2*XW +: XW]), 1120);
    check_val("rst_py2", 32'(pipe_y[20 +: 10]), 190);

    // ticks in IDLE must not move pipes; held start gives one transition
    do_ticks(5);
    check_val("idle_px0", 32'(pipe_x[0 +: XW]), 640);
    start_button = 1'b1;
    cycle();
    check_val("start_state", 32'(state), 1);
    repeat (9) cycle();
    check_val("start_hold", 32'(state), 1);
    start_button = 1'b0;
    cycle();

    // game 1: scroll, score, wrap and gap clamp
    use_forced = 1'b1;
    do_ticks(591);
    check_val("t591_px0", 32'(pipe_x[0 +: XW]), 49);
    check_val("t591_score", 32'(score), 1);
    do_ticks(49);
    check_val("t640_px0", 32'(pipe_x[0 +: XW]), 0);
    forced_seed = 0;
    do_ticks(1);
    check_val("t641_px0", 32'(pipe_x[0 +: XW]), 719);
    check_val("t641_px1", 32'(pipe_x[XW +: XW]), 239);
    check_val("clamp_lo", 32'(pipe_y[0 +: 10]), 20);
    forced_seed = 1000;
    do_ticks(720);
    check_val("clamp_hi", 32'(pipe_y[0 +: 10]), 360);
    check_val("t1361_score", 32'(score), 4);

    // floor collision and death sequence
    follow = 1'b0;
    bird_y = 10'd460;
    cycle();
    check_val("floor_coll", 32'(collision_out), 1);
    cycle();
    check_val("floor_dying", 32'(state), 2);
    do_ticks(29);
    check_val("dying_29", 32'(state), 2);
    do_ticks(1);
    check_val("over", 32'(state), 3);

    // restart from OVER
    follow = 1'b1;
    press_start();
    check_val("restart_state", 32'(state), 1);
    check_val("restart_score", 32'(score), 0);
    check_val("restart_px0", 32'(pipe_x[0 +: XW]), 640);
    check_val("restart_coll", 32'(collision_out), 0);
`ifdef GAME_CTRL_HISCORE_EN
    check_val("hi_keep", 32'(hi_score), 4);
`endif

    // game 2: pipe collision, tick coincident with DYING entry is not counted
    do_ticks(521);
    check_val("t521_px0", 32'(pipe_x[0 +: XW]), 119);
    follow = 1'b0;
    bird_y = 10'd100;
    cycle();
    check_val("pipe_coll", 32'(collision_out), 1);
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    check_val("pipe_dying", 32'(state), 2);
    do_ticks(29);
    check_val("pipe_dying_29", 32'(state), 2);
    do_ticks(1);
    check_val("pipe_over", 32'(state), 3);

    // mid-game asynchronous reset
    follow = 1'b1;
    press_start();
    do_ticks(40);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    push_expect(); compare_all();
    @(posedge clk); #1;
    push_expect(); compare_all();
    reset = 1'b1;

    // random play
    use_forced = 1'b0;
    follow = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      start_button = ($urandom_range(0, 7) == 0);
      frame_tick = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 60) == 0) bird_y = 10'd470;
      else bird_y = 10'(safe_y() - 3 + $urandom_range(0, 86));
      gap_seed = 10'($urandom_range(0, 1023));
      cycle();
    end
    frame_tick = 1'b0;
    start_button = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
